// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared widths, defaults and slot record for the hazard scoreboard
package hazard_scoreboard_pkg;

    localparam int HZ_NUM_SLOTS   = 3;
    localparam int HZ_TNEW_W      = 2;
    localparam int HZ_MULT_CYCLES = 5;
    localparam int HZ_DIV_CYCLES  = 10;
    localparam int HZ_MD_CNT_W    = 4;

    // Tuse value meaning "operand never read"; no tnew can exceed it, so it never stalls
    localparam logic [HZ_TNEW_W-1:0] TNEW_NEVER = '1;

    // One in-flight writer: valid, destination GPR, cycles until forwardable
    typedef struct packed {
        logic                 v;
        logic [4:0]           dst;
        logic [HZ_TNEW_W-1:0] tnew;
    } slot_t;

    // Age a tnew by one stage, saturating at zero
    function automatic logic [HZ_TNEW_W-1:0] tnew_dec(input logic [HZ_TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - HZ_TNEW_W'(1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - D-stage decode / hazard unit connection bundle
interface hazard_scoreboard_if;
    import hazard_scoreboard_pkg::*;

    logic                 D_valid;
    logic [4:0]           D_rs;
    logic [4:0]           D_rt;
    logic [HZ_TNEW_W-1:0] D_tuse_rs;
    logic [HZ_TNEW_W-1:0] D_tuse_rt;
    logic                 D_we;
    logic [4:0]           D_dst;
    logic [HZ_TNEW_W-1:0] D_tnew;
    logic                 D_md_start;
    logic                 D_md_div;
    logic                 D_hilo_use;
    logic                 flush;
    logic                 stall;
    logic                 md_busy;

    // Decode stage side: presents the instruction, receives the stall
    modport master (
        output D_valid, D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_we, D_dst, D_tnew,
        output D_md_start, D_md_div, D_hilo_use, flush,
        input  stall, md_busy
    );

    // Hazard unit side
    modport slave (
        input  D_valid, D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_we, D_dst, D_tnew,
        input  D_md_start, D_md_div, D_hilo_use, flush,
        output stall, md_busy
    );

endinterface

// File: rtl/hazard_md_counter.sv
// rtl/hazard_md_counter.sv - HI/LO busy down-counter for the multi-cycle mult/div unit
module hazard_md_counter #(
    parameter int CNT_W       = 4,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic div,
    output logic busy
);

    logic [CNT_W-1:0] cnt;

    // Load the unit latency on issue, otherwise count down to idle; flush has no effect here
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - D-stage hazard unit: writer scoreboard plus mult/div busy; HAZARD_PERF_EN adds stall counters
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_SLOTS   = HZ_NUM_SLOTS,
    parameter int MULT_CYCLES = HZ_MULT_CYCLES,
    parameter int DIV_CYCLES  = HZ_DIV_CYCLES,
    parameter int MD_CNT_W    = HZ_MD_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_scoreboard_if.slave   hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_hilo_cnt
`endif
);

    slot_t                slots [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] hit_rs;
    logic [NUM_SLOTS-1:0] hit_rt;
    logic                 stall_hilo;
    logic                 stall_int;
    logic                 issue;
    logic                 md_busy;

    // Per-slot RAW check; $0 is hard-wired so it never creates a dependency
    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_cmp
        assign hit_rs[k] = slots[k].v && (slots[k].dst != 5'd0) &&
                           (slots[k].dst == hz.D_rs) && (slots[k].tnew > hz.D_tuse_rs);
        assign hit_rt[k] = slots[k].v && (slots[k].dst != 5'd0) &&
                           (slots[k].dst == hz.D_rt) && (slots[k].tnew > hz.D_tuse_rt);
    end

    // Combine operand and HI/LO hazards; a flush overrides everything since D is being killed
    always_comb begin
        stall_hilo = hz.D_valid & hz.D_hilo_use & md_busy;
        stall_int  = 1'b0;
        if (!hz.flush) begin
            stall_int = (hz.D_valid & (|hit_rs | |hit_rt)) | stall_hilo;
        end
        issue = hz.D_valid & ~stall_int & ~hz.flush;
    end

    // Shift writers down the pipe; stalls and flushes feed a bubble, flush also kills the E occupant
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slots[k] <= '0;
            end
        end else begin
            if (issue && hz.D_we) begin
                slots[0] <= '{v: 1'b1, dst: hz.D_dst, tnew: hz.D_tnew};
            end else begin
                slots[0] <= '0;
            end
            for (int k = 1; k < NUM_SLOTS; k++) begin
                slots[k].v    <= slots[k-1].v & ~((k == 1) & hz.flush);
                slots[k].dst  <= slots[k-1].dst;
                slots[k].tnew <= tnew_dec(slots[k-1].tnew);
            end
        end
    end

    hazard_md_counter #(
        .CNT_W       (MD_CNT_W),
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_counter (
        .clk   (clk),
        .reset (reset),
        .load  (issue & hz.D_md_start),
        .div   (hz.D_md_div),
        .busy  (md_busy)
    );

    assign hz.stall   = stall_int;
    assign hz.md_busy = md_busy;

`ifdef HAZARD_PERF_EN
    // Saturating event counters for stall cycles and HI/LO stall cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_hilo_cnt  <= '0;
        end else begin
            if (stall_int && perf_stall_cnt != 32'hFFFF_FFFF) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (stall_hilo && perf_hilo_cnt != 32'hFFFF_FFFF) begin
                perf_hilo_cnt <= perf_hilo_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed table-driven bench for hazard_scoreboard
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam logic [1:0] N = TNEW_NEVER;

    logic clk;
    logic reset;
    hazard_scoreboard_if hz();
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_hilo_cnt;
`endif

    hazard_scoreboard dut (
        .clk            (clk),
        .reset          (reset),
        .hz             (hz)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_hilo_cnt  (perf_hilo_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        bit         rst;
        bit         vld;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] trs;
        logic [1:0] trt;
        bit         we;
        logic [4:0] dst;
        logic [1:0] tnew;
        bit         mds;
        bit         mdd;
        bit         hilo;
        bit         fl;
        bit         es;
        bit         eb;
    } row_t;

    row_t rows[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add_row(input string nm, input bit rst, input bit vld,
                           input logic [4:0] rs, input logic [4:0] rt,
                           input logic [1:0] trs, input logic [1:0] trt,
                           input bit we, input logic [4:0] dst, input logic [1:0] tnew,
                           input bit mds, input bit mdd, input bit hilo, input bit fl,
                           input bit es, input bit eb);
        row_t r;
        r = '{nm, rst, vld, rs, rt, trs, trt, we, dst, tnew, mds, mdd, hilo, fl, es, eb};
        rows.push_back(r);
    endtask

    task automatic drive(input row_t r);
        reset         = r.rst;
        hz.D_valid    = r.vld;
        hz.D_rs       = r.rs;
        hz.D_rt       = r.rt;
        hz.D_tuse_rs  = r.trs;
        hz.D_tuse_rt  = r.trt;
        hz.D_we       = r.we;
        hz.D_dst      = r.dst;
        hz.D_tnew     = r.tnew;
        hz.D_md_start = r.mds;
        hz.D_md_div   = r.mdd;
        hz.D_hilo_use = r.hilo;
        hz.flush      = r.fl;
    endtask

    task automatic check(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        row_t idle;
        row_t r;
        int   cyc;
        idle = '{"idle", 1'b0, 1'b0, 5'd0, 5'd0, N, N, 1'b0, 5'd0, 2'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        //        name          rst vld rs  rt  trs trt we dst tn mds mdd hl fl  stall busy
        add_row("reset_state",  0, 0,  0,  0,  N,  N,  0, 0,  0, 0, 0, 0, 0,  0, 0);
        // lw $8 then dependent addu: one stall cycle
        add_row("t1_lw",        0, 1, 29,  0,  1,  N,  1, 8,  2, 0, 0, 0, 0,  0, 0);
        add_row("t1_addu_stl",  0, 1,  8,  9,  1,  1,  1, 10, 1, 0, 0, 0, 0,  1, 0);
        add_row("t1_addu_go",   0, 1,  8,  9,  1,  1,  1, 10, 1, 0, 0, 0, 0,  0, 0);
        add_row("t1_br_stl",    0, 1, 10,  0,  0,  N,  0, 0,  0, 0, 0, 0, 0,  1, 0);
        add_row("t1_br_go",     0, 1, 10,  0,  0,  N,  0, 0,  0, 0, 0, 0, 0,  0, 0);
        // lw $8 then sw storing $8 late: tnew == tuse never stalls
        add_row("t2_lw",        0, 1, 29,  0,  1,  N,  1, 8,  2, 0, 0, 0, 0,  0, 0);
        add_row("t2_sw",        0, 1, 29,  8,  1,  2,  0, 0,  0, 0, 0, 0, 0,  0, 0);
        add_row("t2_idle",      0, 0,  0,  0,  N,  N,  0, 0,  0, 0, 0, 0, 0,  0, 0);
        // writer to $0 never blocks a $0 reader
        add_row("t5_wr0",       0, 1,  1,  0,  1,  N,  1, 0,  2, 0, 0, 0, 0,  0, 0);
        add_row("t5_rd0",       0, 1,  0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 0,  0, 0);
        // flush with lw $9 in E: no stall now, E occupant killed
        add_row("t6_lw9",       0, 1, 29,  0,  1,  N,  1, 9,  2, 0, 0, 0, 0,  0, 0);
        add_row("t6_beq_flush", 0, 1,  9,  0,  0,  0,  0, 0,  0, 0, 0, 0, 1,  0, 0);
        add_row("t6_beq_after", 0, 1,  9,  0,  0,  0,  0, 0,  0, 0, 0, 0, 0,  0, 0);
        // mult then mflo: five stall cycles, release together with md_busy
        add_row("t3_mult",      0, 1,  4,  5,  1,  1,  0, 0,  0, 1, 0, 1, 0,  0, 0);
        for (int i = 0; i < 5; i++)
            add_row("t3_mflo_stl", 0, 1, 0, 0, N, N, 1, 2, 1, 0, 0, 1, 0, 1, 1);
        add_row("t3_mflo_go",   0, 1,  0,  0,  N,  N,  1, 2,  1, 0, 0, 1, 0,  0, 0);
        // div then reset mid-countdown
        add_row("t4_div",       0, 1,  4,  5,  1,  1,  0, 0,  0, 1, 1, 1, 0,  0, 0);
        add_row("t4_idle",      0, 0,  0,  0,  N,  N,  0, 0,  0, 0, 0, 0, 0,  0, 1);
        add_row("t4_lw12",      0, 1, 29,  0,  1,  N,  1, 12, 2, 0, 0, 0, 0,  0, 1);
        add_row("t4_mfhi_rst",  1, 1,  0,  0,  N,  N,  1, 3,  1, 0, 0, 1, 0,  1, 1);
        add_row("t4_mfhi_post", 0, 1, 12,  0,  0,  N,  1, 3,  1, 0, 0, 1, 0,  0, 0);
        // flush does not abort an issued div
        add_row("fl_div",       0, 1,  4,  5,  1,  1,  0, 0,  0, 1, 1, 1, 0,  0, 0);
        add_row("fl_mfhi",      0, 1,  0,  0,  N,  N,  1, 3,  1, 0, 0, 1, 1,  0, 1);
        add_row("fl_idle",      0, 0,  0,  0,  N,  N,  0, 0,  0, 0, 0, 0, 0,  0, 1);

        r = idle;
        r.rst = 1'b1;
        drive(r);
        repeat (2) @(negedge clk);

        foreach (rows[i]) begin
            @(negedge clk);
            drive(rows[i]);
            #2;
            check({rows[i].nm, "_stall"}, hz.stall, rows[i].es);
            check({rows[i].nm, "_busy"}, hz.md_busy, rows[i].eb);
        end

        // tnew=3 writer walks through all three slots: reader with tuse=0 waits 3 cycles
        @(negedge clk);
        r = idle;
        r.rst = 1'b1;
        drive(r);
        @(negedge clk);
        r = idle;
        r.vld = 1'b1; r.rs = 5'd29; r.trs = 2'd1; r.we = 1'b1; r.dst = 5'd13; r.tnew = 2'd3;
        drive(r);
        #2;
        check("long_lw_stall", hz.stall, 1'b0);
        check("long_lw_busy", hz.md_busy, 1'b0);
        r = idle;
        r.vld = 1'b1; r.rs = 5'd13; r.trs = 2'd0;
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(r);
            #2;
            if (hz.stall !== 1'b1) break;
            cyc++;
        end
        check_int("long_stall_cycles", cyc, 3);

        // same reader one step later reads rt with tuse=1: only two stall cycles
        @(negedge clk);
        r = idle;
        r.vld = 1'b1; r.rs = 5'd29; r.trs = 2'd1; r.we = 1'b1; r.dst = 5'd14; r.tnew = 2'd3;
        drive(r);
        r = idle;
        r.vld = 1'b1; r.rt = 5'd14; r.trt = 2'd1;
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(r);
            #2;
            if (hz.stall !== 1'b1) break;
            cyc++;
        end
        check_int("rt_stall_cycles", cyc, 2);

        @(negedge clk);
        drive(idle);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
